// File: rtl/sprite_anim_mapper.sv
// Positioned, scaled, mirrored, animated sprite to sync-ROM address mapper.
// Two-stage pixel pipeline: address/hit, then registered colour.
module sprite_anim_mapper #(
  parameter int SPR_W      = 40,
  parameter int SPR_H      = 66,
  parameter int SCALE_LOG2 = 0,
  parameter int N_FRAMES   = 4,
  parameter int FRAME_DIV  = 6,
  parameter int TRANS_IDX  = 0,
  parameter int ADDR_W     = 15,
  localparam int FW = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic              mirror,
  input  logic              frame_tick,
  input  logic              anim_en,
  input  logic              anim_restart,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3:0]        rom_q,
  input  logic [3:0]        pal_red,
  input  logic [3:0]        pal_green,
  input  logic [3:0]        pal_blue,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              pixel_on,
  output logic [FW-1:0]     cur_frame
);

  localparam int WS  = SPR_W << SCALE_LOG2;
  localparam int HS  = SPR_H << SCALE_LOG2;
  localparam int FSZ = SPR_W * SPR_H;
  localparam int DW  = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  logic [9:0]    sx_q, sy_q;
  logic          mir_q;
  logic [DW-1:0] div_q, div_d;
  logic [FW-1:0] frame_q, frame_d;
  logic          hit_q, blank_q;
  logic [3:0]    red_q, green_q, blue_q;
  logic          on_q;

  logic [10:0] x11, y11, sx11, sy11;
  logic [10:0] dx, dy, col, row, colm;
  logic        hit, on;

  assign x11  = {1'b0, DrawX};
  assign y11  = {1'b0, DrawY};
  assign sx11 = {1'b0, sx_q};
  assign sy11 = {1'b0, sy_q};

  assign hit = (x11 >= sx11) && (x11 < sx11 + 11'(WS)) &&
               (y11 >= sy11) && (y11 < sy11 + 11'(HS));

  assign dx   = x11 - sx11;
  assign dy   = y11 - sy11;
  assign col  = dx >> SCALE_LOG2;
  assign row  = dy >> SCALE_LOG2;
  assign colm = mir_q ? (11'(SPR_W - 1) - col) : col;

  always_comb begin
    rom_addr = '0;
    if (hit) begin
      rom_addr = ADDR_W'(frame_q) * ADDR_W'(FSZ) +
                 ADDR_W'(row) * ADDR_W'(SPR_W) +
                 ADDR_W'(colm);
    end
  end

  // Restart beats a coincident tick; anim_en gates only the animation.
  always_comb begin
    div_d   = div_q;
    frame_d = frame_q;
    if (anim_restart) begin
      div_d   = '0;
      frame_d = '0;
    end else if (frame_tick && anim_en) begin
      if (div_q == DW'(FRAME_DIV - 1)) begin
        div_d   = '0;
        frame_d = (frame_q == FW'(N_FRAMES - 1)) ? '0 : frame_q + 1'b1;
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  assign on = hit_q & blank_q & (rom_q != 4'(TRANS_IDX));

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      sx_q    <= '0;
      sy_q    <= '0;
      mir_q   <= 1'b0;
      div_q   <= '0;
      frame_q <= '0;
      hit_q   <= 1'b0;
      blank_q <= 1'b0;
      on_q    <= 1'b0;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
    end else begin
      if (frame_tick) begin
        sx_q  <= pos_x;
        sy_q  <= pos_y;
        mir_q <= mirror;
      end
      div_q   <= div_d;
      frame_q <= frame_d;
      hit_q   <= hit;
      blank_q <= blank;
      on_q    <= on;
      red_q   <= on ? pal_red   : 4'd0;
      green_q <= on ? pal_green : 4'd0;
      blue_q  <= on ? pal_blue  : 4'd0;
    end
  end

  assign red       = red_q;
  assign green     = green_q;
  assign blue      = blue_q;
  assign pixel_on  = on_q;
  assign cur_frame = frame_q;

endmodule
